// File: rtl/seller_ctrl.sv
// Vending-machine seller controller: coin credit, product vend handshake, change payout.
// Optional vend timeout with refund is enabled by defining SELLER_TIMEOUT_EN.
module seller_ctrl #(
  parameter int PRICE_A  = 3,
  parameter int PRICE_B  = 5,
  parameter int CREDIT_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_d1,
  input  logic                i_d2,
  input  logic                i_d3,
  input  logic                i_sel_a,
  input  logic                i_sel_b,
  input  logic                i_cancel,
  input  logic                i_vend_ack,
  input  logic                i_chg_ack,
  output logic                o_vend_req,
  output logic                o_vend_id,
  output logic                o_chg_req,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_coin_rej,
  output logic                o_busy,
  output logic                o_fault
);

  typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

  localparam logic [CREDIT_W:0]   LP_MAX     = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W-1:0] LP_PRICE_A = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] LP_PRICE_B = CREDIT_W'(PRICE_B);

  state_t              r_state;
  logic                r_vend_req;
  logic                r_vend_id;
  logic                r_chg_req;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_coin_rej;
  logic                r_busy;
`ifdef SELLER_TIMEOUT_EN
  logic                r_fault;
  logic [3:0]          r_tmo;
`endif

  logic                w_any_coin;
  logic                w_extra_coin;
  logic [2:0]          w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_sat;
  logic                w_sel_any;
  logic [CREDIT_W-1:0] w_sel_price;
  logic                w_sel_ok;
  logic                w_cancel_ok;
  logic                w_coin_take;
  logic [CREDIT_W-1:0] w_vend_price;
  logic [CREDIT_W-1:0] w_remain;

  // Only the highest-priority coin can be banked; any other coin in the same cycle bounces.
  assign w_any_coin   = i_d1 | i_d2 | i_d3;
  assign w_extra_coin = (i_d1 & (i_d2 | i_d3)) | (i_d2 & i_d3);
  assign w_coin_val   = i_d1 ? 3'd1 : (i_d2 ? 3'd2 : (i_d3 ? 3'd4 : 3'd0));
  assign w_sum        = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_val);
  assign w_sat        = (w_sum > LP_MAX);

  // sel_a outranks sel_b; a selection pulse always blocks coin intake that cycle.
  assign w_sel_any    = i_sel_a | i_sel_b;
  assign w_sel_price  = i_sel_a ? LP_PRICE_A : LP_PRICE_B;
  assign w_sel_ok     = w_sel_any && (r_credit >= w_sel_price);
  assign w_cancel_ok  = i_cancel && (r_credit != '0) && !w_sel_ok;
  assign w_coin_take  = w_any_coin && !w_sel_any && !w_cancel_ok && !w_sat;

  assign w_vend_price = r_vend_id ? LP_PRICE_B : LP_PRICE_A;
  assign w_remain     = r_credit - w_vend_price;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_vend_req <= 1'b0;
      r_vend_id  <= 1'b0;
      r_chg_req  <= 1'b0;
      r_credit   <= '0;
      r_coin_rej <= 1'b0;
      r_busy     <= 1'b0;
`ifdef SELLER_TIMEOUT_EN
      r_fault    <= 1'b0;
      r_tmo      <= '0;
`endif
    end else begin
      r_coin_rej <= 1'b0;
`ifdef SELLER_TIMEOUT_EN
      r_fault    <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_coin_rej <= w_any_coin && (!w_coin_take || w_extra_coin);
          if (w_sel_ok) begin
            r_state    <= S_VEND;
            r_vend_req <= 1'b1;
            r_vend_id  <= ~i_sel_a;
            r_busy     <= 1'b1;
`ifdef SELLER_TIMEOUT_EN
            r_tmo      <= '0;
`endif
          end else if (w_cancel_ok) begin
            r_state   <= S_CHANGE;
            r_chg_req <= 1'b1;
            r_busy    <= 1'b1;
          end else if (w_coin_take) begin
            r_credit <= w_sum[CREDIT_W-1:0];
          end
        end

        S_VEND: begin
          r_coin_rej <= w_any_coin;
          if (i_vend_ack) begin
            r_vend_req <= 1'b0;
            r_credit   <= w_remain;
            if (w_remain != '0) begin
              r_state   <= S_CHANGE;
              r_chg_req <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
`ifdef SELLER_TIMEOUT_EN
          // Counter holds 14 on the 15th cycle after vend_req rose: give up and refund.
          else if (r_tmo == 4'd14) begin
            r_vend_req <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= S_CHANGE;
            r_chg_req  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 4'd1;
          end
`endif
        end

        S_CHANGE: begin
          r_coin_rej <= w_any_coin;
          if (i_chg_ack) begin
            r_credit <= r_credit - 1'b1;
            if (r_credit <= CREDIT_W'(1)) begin
              r_state   <= S_IDLE;
              r_chg_req <= 1'b0;
              r_busy    <= 1'b0;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_vend_req <= 1'b0;
          r_chg_req  <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_vend_req = r_vend_req;
  assign o_vend_id  = r_vend_id;
  assign o_chg_req  = r_chg_req;
  assign o_credit   = r_credit;
  assign o_coin_rej = r_coin_rej;
  assign o_busy     = r_busy;
`ifdef SELLER_TIMEOUT_EN
  assign o_fault    = r_fault;
`else
  assign o_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_seller_ctrl.sv
// Directed self-checking bench for seller_ctrl with hand-computed expectations.
// Covers the timeout path when built with SELLER_TIMEOUT_EN, otherwise checks indefinite wait.
module tb_seller_ctrl;

  localparam logic [7:0] D1 = 8'h80;
  localparam logic [7:0] D2 = 8'h40;
  localparam logic [7:0] D3 = 8'h20;
  localparam logic [7:0] SA = 8'h10;
  localparam logic [7:0] SB = 8'h08;
  localparam logic [7:0] CN = 8'h04;
  localparam logic [7:0] VA = 8'h02;
  localparam logic [7:0] CA = 8'h01;
  localparam logic [7:0] NO = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic       d1, d2, d3, selA, selB, cancel, vendAck, chgAck;
  logic       vendReq, vendId, chgReq, coinRej, busy, fault;
  logic [3:0] credit;

  int total = 0;
  int bad   = 0;

  seller_ctrl #(.PRICE_A(3), .PRICE_B(5), .CREDIT_W(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_d1       (d1),
    .i_d2       (d2),
    .i_d3       (d3),
    .i_sel_a    (selA),
    .i_sel_b    (selB),
    .i_cancel   (cancel),
    .i_vend_ack (vendAck),
    .i_chg_ack  (chgAck),
    .o_vend_req (vendReq),
    .o_vend_id  (vendId),
    .o_chg_req  (chgReq),
    .o_credit   (credit),
    .o_coin_rej (coinRej),
    .o_busy     (busy),
    .o_fault    (fault)
  );

  always #5 clk = ~clk;

  // Present one input vector for exactly one rising edge, then settle 1 ns past it.
  task automatic applyStimulus(input logic [7:0] vec);
    {d1, d2, d3, selA, selB, cancel, vendAck, chgAck} = vec;
    @(posedge clk);
    #1;
    {d1, d2, d3, selA, selB, cancel, vendAck, chgAck} = 8'h00;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int expCredit, input int expVreq,
                          input int expChg, input int expBusy, input int expRej);
    checkOutput({tag, ".credit"}, int'(credit), expCredit);
    checkOutput({tag, ".vend_req"}, int'(vendReq), expVreq);
    checkOutput({tag, ".chg_req"}, int'(chgReq), expChg);
    checkOutput({tag, ".busy"}, int'(busy), expBusy);
    checkOutput({tag, ".coin_rej"}, int'(coinRej), expRej);
  endtask

  initial begin
    rst = 1'b1;
    {d1, d2, d3, selA, selB, cancel, vendAck, chgAck} = 8'h00;
    applyStimulus(NO);
    checkAll("reset", 0, 0, 0, 0, 0);
    checkOutput("reset.fault", int'(fault), 0);
    checkOutput("reset.vend_id", int'(vendId), 0);
    rst = 1'b0;

    // Product A with exact credit.
    applyStimulus(D2);  checkAll("a.d2", 2, 0, 0, 0, 0);
    applyStimulus(D1);  checkAll("a.d1", 3, 0, 0, 0, 0);
    applyStimulus(SA);  checkAll("a.sel", 3, 1, 0, 1, 0);
    checkOutput("a.vend_id", int'(vendId), 0);
    applyStimulus(NO);  checkAll("a.hold", 3, 1, 0, 1, 0);
    applyStimulus(VA);  checkAll("a.ack", 0, 0, 0, 0, 0);

    // Product B with one unit of change.
    applyStimulus(D3);  checkAll("b.d3", 4, 0, 0, 0, 0);
    applyStimulus(D2);  checkAll("b.d2", 6, 0, 0, 0, 0);
    applyStimulus(SB);  checkAll("b.sel", 6, 1, 0, 1, 0);
    checkOutput("b.vend_id", int'(vendId), 1);
    applyStimulus(VA);  checkAll("b.ack", 1, 0, 1, 1, 0);
    applyStimulus(CA);  checkAll("b.chg", 0, 0, 0, 0, 0);
    applyStimulus(CA | VA);  checkAll("b.stray_ack", 0, 0, 0, 0, 0);

    // Insufficient selection, coin priority, coin+selection collision.
    applyStimulus(D1);       checkAll("c.d1", 1, 0, 0, 0, 0);
    applyStimulus(SB);       checkAll("c.poor_sel", 1, 0, 0, 0, 0);
    applyStimulus(D1 | D3);  checkAll("c.prio", 2, 0, 0, 0, 1);
    applyStimulus(NO);       checkAll("c.rej_pulse", 2, 0, 0, 0, 0);
    applyStimulus(D1);       checkAll("c.d1b", 3, 0, 0, 0, 0);
    applyStimulus(D2 | SA);  checkAll("c.coin_sel", 3, 1, 0, 1, 1);
    applyStimulus(D1);       checkAll("c.coin_vend", 3, 1, 0, 1, 1);
    applyStimulus(CN);       checkAll("c.cancel_vend", 3, 1, 0, 1, 0);
    applyStimulus(VA);       checkAll("c.ack", 0, 0, 0, 0, 0);
    applyStimulus(CN);       checkAll("c.cancel_zero", 0, 0, 0, 0, 0);

    // Saturation at 14, then cancel and full refund.
    applyStimulus(D3);  applyStimulus(D3);  applyStimulus(D3);
    applyStimulus(D2);  checkAll("s.fill", 14, 0, 0, 0, 0);
    applyStimulus(D2);  checkAll("s.sat", 14, 0, 0, 0, 1);
    applyStimulus(CN);  checkAll("s.cancel", 14, 0, 1, 1, 0);
    applyStimulus(D1);  checkAll("s.coin_chg", 14, 0, 1, 1, 1);
    for (int i = 13; i >= 1; i--) begin
      applyStimulus(CA);
      checkAll("s.refund", i, 0, 1, 1, 0);
    end
    applyStimulus(CA);  checkAll("s.done", 0, 0, 0, 0, 0);

    // Reset in the middle of a payout discards credit.
    applyStimulus(D1);  applyStimulus(D2);
    applyStimulus(CN);  checkAll("r.cancel", 3, 0, 1, 1, 0);
    rst = 1'b1;
    applyStimulus(CA);  checkAll("r.reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Selection beats cancel.
    applyStimulus(D1);  applyStimulus(D2);
    applyStimulus(SA | CN);  checkAll("x.sel_cancel", 3, 1, 0, 1, 0);
    applyStimulus(VA);       checkAll("x.ack", 0, 0, 0, 0, 0);

    // Vend with no acknowledge.
    applyStimulus(D3);  applyStimulus(SA);  checkAll("t.sel", 4, 1, 0, 1, 0);
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(NO);
      checkAll("t.wait", 4, 1, 0, 1, 0);
      checkOutput("t.wait.fault", int'(fault), 0);
    end
`ifdef SELLER_TIMEOUT_EN
    applyStimulus(NO);  checkAll("t.timeout", 4, 0, 1, 1, 0);
    checkOutput("t.fault", int'(fault), 1);
    applyStimulus(NO);  checkOutput("t.fault_pulse", int'(fault), 0);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(CA);
      checkAll("t.refund", i, 0, (i != 0) ? 1 : 0, (i != 0) ? 1 : 0, 0);
    end
`else
    for (int k = 0; k < 6; k++) begin
      applyStimulus(NO);
      checkAll("t.forever", 4, 1, 0, 1, 0);
      checkOutput("t.no_fault", int'(fault), 0);
    end
    applyStimulus(VA);  checkAll("t.ack", 1, 0, 1, 1, 0);
    applyStimulus(CA);  checkAll("t.chg", 0, 0, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seller_ctrl.md
SELLER_CTRL -- requirements
Module: seller_ctrl

Interface
REQ-001 Parameter PRICE_A, default 3, price of product A in 0.5-unit steps (1.5).
REQ-002 Parameter PRICE_B, default 5, price of product B in 0.5-unit steps (2.5).
REQ-003 Parameter CREDIT_W, default 4, credit register width; maximum credit is 2^CREDIT_W-1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 d1 / d2 / d3  in  1 each  coin pulses worth 0.5 / 1 / 2, i.e. 1 / 2 / 4 units.
REQ-007 sel_a / sel_b  in  1 each  product select pulses.
REQ-008 cancel  in  1  refund request pulse.
REQ-009 vend_ack  in  1  dispenser completion strobe.
REQ-010 chg_ack  in  1  change dispenser accepted one 0.5 coin.
REQ-011 vend_req  out  1  dispense request, level, held until acknowledged.
REQ-012 vend_id  out  1  product being dispensed: 0 = A, 1 = B.
REQ-013 chg_req  out  1  change-coin request, level.
REQ-014 credit  out  CREDIT_W  current credit in units.
REQ-015 coin_rej  out  1  one-cycle pulse marking a refused coin.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 fault  out  1  one-cycle vend-timeout pulse.

Function
REQ-018 FSM states SHALL be IDLE, VEND and CHANGE; all outputs SHALL be registered.
REQ-019 Coins in IDLE: the coin SHALL be added to credit on the next edge; if d1, d2 and d3 coincide, priority SHALL be d1 > d2 > d3 and each lower-priority coin present SHALL cause coin_rej.
REQ-020 Saturation: a coin that would push credit above 2^CREDIT_W-1 SHALL be refused (credit unchanged, coin_rej = 1).
REQ-021 Coins arriving in VEND or CHANGE SHALL be refused with coin_rej.
REQ-022 Selection in IDLE with credit >= price: transition to VEND; vend_req = 1 and vend_id set on the edge after the selection (latency 1).
REQ-023 Selection with credit < price SHALL be ignored; if sel_a and sel_b coincide, sel_a SHALL win.
REQ-024 A coin and a selection in the same cycle: the coin SHALL be refused and the selection evaluated against the old credit.
REQ-025 VEND: vend_req SHALL hold until vend_ack; the edge after vend_ack SHALL clear vend_req and subtract the price from credit, then go to CHANGE if the remainder > 0, else IDLE.
REQ-026 cancel in IDLE with credit > 0 SHALL go to CHANGE; cancel with credit 0, or in VEND or CHANGE, SHALL be ignored.
REQ-027 CHANGE: chg_req = 1; each cycle with chg_ack SHALL decrement credit by 1; the edge that brings credit to 0 SHALL clear chg_req and return to IDLE.
REQ-028 vend_ack outside VEND and chg_ack outside CHANGE SHALL be ignored.
REQ-029 Selection and cancel in the same IDLE cycle: the selection SHALL win.

Reset
REQ-030 rst SHALL force IDLE, credit = 0 and all outputs 0 on the next edge, overriding every other input, including mid-VEND or mid-CHANGE (credit discarded).

Configuration
REQ-031 With SELLER_TIMEOUT_EN defined, a 4-bit counter SHALL run in VEND.
REQ-032 With SELLER_TIMEOUT_EN defined, no vend_ack within 15 cycles of vend_req rising SHALL: clear vend_req, pulse fault, keep credit unchanged and enter CHANGE to refund it.
REQ-033 Without SELLER_TIMEOUT_EN, VEND SHALL wait indefinitely and fault SHALL be tied to 0.

Verification
REQ-034 Coins d2, d1, then sel_a, then vend_ack -> credit 2, 3; vend_req = 1 with vend_id = 0; after the ack credit = 0, IDLE, chg_req never asserted.
REQ-035 Coins d3, d2, then sel_b, then vend_ack, then chg_ack x1 -> credit 6; vend_id = 1; credit 1 after the ack; chg_req for exactly one ack; then IDLE.
REQ-036 Credit 1, sel_b -> ignored, busy stays 0; then d1 and d3 in the same cycle -> credit 2 and coin_rej = 1.
REQ-037 Credit 14, d2 -> coin_rej = 1, credit stays 14; then cancel and 14 chg_ack -> credit counts down to 0 and the block returns to IDLE.
REQ-038 Reset mid-CHANGE at credit 3 -> next cycle credit = 0, chg_req = 0, busy = 0.
REQ-039 With SELLER_TIMEOUT_EN defined: credit 4, sel_a, no vend_ack -> fault pulses 15 cycles after vend_req rises; CHANGE refunds all 4 units.
